// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch-stage parameter defaults and the fetch FSM state type.
package proc_pkg;

   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_INST_BYTES = 2;
   localparam int unsigned DEF_PC_RESET   = 0;

   typedef enum logic [1:0] {
      RUN,
      WAIT,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register between fetch and decode; flush drops the held entry.
module fetch_out_reg
   import proc_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              flush,
   input  logic              ready,
   input  logic [DATA_W-1:0] instIn,
   input  logic [DATA_W-1:0] pcIn,
   input  logic [DATA_W-1:0] pcPlusIn,
   output logic              valid,
   output logic [DATA_W-1:0] inst,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] pcPlus
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         inst   <= '0;
         pc     <= '0;
         pcPlus <= '0;
      end else begin
         if (flush)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         else if (ready)
            valid <= 1'b0;
         if (load && !flush) begin
            inst   <= instIn;
            pc     <= pcIn;
            pcPlus <= pcPlusIn;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding and feeds decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
   import proc_pkg::*;
#(
   parameter int unsigned       DATA_W     = DEF_DATA_W,
   parameter int unsigned       INST_BYTES = DEF_INST_BYTES,
   parameter logic [DATA_W-1:0] PC_RESET   = DATA_W'(DEF_PC_RESET)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect,
   input  logic [DATA_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_rvalid,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [DATA_W-1:0] if_inst,
   output logic [DATA_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_pc_plus,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`endif
);

   fetch_state_t      state, stateNext;
   logic [DATA_W-1:0] pc, pcNext, reqAddr, reqAddrNext, pcInc;
   logic              kill, killNext, load, flush, canIssue;

   assign pcInc    = pc + DATA_W'(INST_BYTES);
   assign canIssue = !if_valid || if_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         pc      <= PC_RESET;
         reqAddr <= '0;
         kill    <= 1'b0;
      end else begin
         state   <= stateNext;
         pc      <= pcNext;
         reqAddr <= reqAddrNext;
         kill    <= killNext;
      end
   end

   // A redirect while a request is in flight keeps the request alive but marks its data stale.
   always_comb begin
      stateNext   = state;
      pcNext      = pc;
      reqAddrNext = reqAddr;
      killNext    = kill;
      imem_req    = 1'b0;
      load        = 1'b0;
      flush       = 1'b0;
      unique case (state)
         RUN: begin
            if (halt) begin
               stateNext = HALT;
            end else if (redirect) begin
               flush  = 1'b1;
               pcNext = redirect_pc;
            end else if (canIssue && rst_n) begin
               imem_req    = 1'b1;
               reqAddrNext = pc;
               stateNext   = WAIT;
            end
         end
         WAIT: begin
            imem_req = 1'b1;
            if (halt) begin
               stateNext = HALT;
            end else begin
               if (redirect) begin
                  flush  = 1'b1;
                  pcNext = redirect_pc;
               end
               if (imem_rvalid) begin
                  killNext  = 1'b0;
                  stateNext = RUN;
                  if (!kill && !redirect) begin
                     load   = 1'b1;
                     pcNext = pcInc;
                  end
               end else if (redirect) begin
                  killNext = 1'b1;
               end
            end
         end
         HALT: begin
            stateNext = HALT;
         end
         default: begin
            stateNext = RUN;
         end
      endcase
   end

   assign imem_addr = (state == WAIT) ? reqAddr : pc;
   assign halted    = (state == HALT);

   fetch_out_reg #(.DATA_W(DATA_W)) outReg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .flush    (flush),
      .ready    (if_ready),
      .instIn   (imem_rdata),
      .pcIn     (pc),
      .pcPlusIn (pcInc),
      .valid    (if_valid),
      .inst     (if_inst),
      .pc       (if_pc),
      .pcPlus   (if_pc_plus)
   );

`ifdef FETCH_PERF_CNT_EN
   logic ifAccept, stallCycle;

   assign ifAccept   = if_valid && if_ready && !flush;
   assign stallCycle = (state == WAIT) || (if_valid && !if_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else if (state != HALT) begin
         if (ifAccept && (perf_fetched != '1))
            perf_fetched <= perf_fetched + 32'd1;
         if (stallCycle && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order stream model, randomized imem latency,
// backpressure and redirects, plus directed reset/halt/wrap cases.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // DUT 0: PC_RESET = 0, fully driven by the bench model
   logic        redirect, halt, imemRvalid, ifReady;
   logic [15:0] redirectPc, imemRdata;
   logic        imemReq, ifValid, halted;
   logic [15:0] imemAddr, ifInst, ifPc, ifPcPlus;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perfFetched, perfStall;
`endif

   // DUT 1: PC_RESET = 0xFFFE, single-cycle memory, decode always ready
   logic        hiReq, hiValid, hiHalted, hiRv;
   logic [15:0] hiAddr, hiInst, hiPc, hiPcPlus, hiRd;
   logic        hiZero;
   logic [15:0] hiZeroPc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] hiPerfFetched, hiPerfStall;
`endif

   fetch_unit #(.DATA_W(16), .INST_BYTES(2), .PC_RESET(16'h0000)) dut0 (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirectPc), .halt(halt),
      .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(imemRdata), .imem_rvalid(imemRvalid),
      .if_valid(ifValid), .if_ready(ifReady), .if_inst(ifInst), .if_pc(ifPc),
      .if_pc_plus(ifPcPlus), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perfFetched), .perf_stall(perfStall)
`endif
   );

   assign hiZero   = 1'b0;
   assign hiZeroPc = 16'h0000;

   fetch_unit #(.DATA_W(16), .INST_BYTES(2), .PC_RESET(16'hFFFE)) dut1 (
      .clk(clk), .rst_n(rst_n), .redirect(hiZero), .redirect_pc(hiZeroPc), .halt(hiZero),
      .imem_req(hiReq), .imem_addr(hiAddr), .imem_rdata(hiRd), .imem_rvalid(hiRv),
      .if_valid(hiValid), .if_ready(1'b1), .if_inst(hiInst), .if_pc(hiPc),
      .if_pc_plus(hiPcPlus), .halted(hiHalted)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(hiPerfFetched), .perf_stall(hiPerfStall)
`endif
   );

   int checks = 0;
   int failures = 0;

   function automatic logic [15:0] memData(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event within cycle budget", name);
   endtask

   // stimulus knobs and imem model
   int unsigned pReady = 100, pRedir = 0, pSpur = 0, latMin = 1, latMax = 1;
   bit          randIn = 0;
   bit          memBusy = 0;
   logic [15:0] memAddr = '0;
   int unsigned lat = 0;
   bit          nextRv = 0;
   logic [15:0] nextRd = '0;

   // reference model of the instruction stream seen by decode
   logic [15:0] expPc = 16'h0000;
   bit          modelHalted = 0;
   bit          prevHold = 0;
   logic [15:0] prevInst, prevPc, prevPlus;
   logic [15:0] accQ[$];
   logic [15:0] accPlusQ[$];
   int unsigned mFetched = 0, mStall = 0;

   // dut1 capture
   logic [15:0] q1[$];
   logic [15:0] q1Plus[$];
   bit          hiReqS = 0;
   logic [15:0] hiAddrS = '0;

   always @(negedge clk) begin
      hiReqS  = hiReq && !hiRv;
      hiAddrS = hiAddr;
      if (hiValid && q1.size() < 4) begin
         q1.push_back(hiPc);
         q1Plus.push_back(hiPcPlus);
      end
   end

   always @(posedge clk) begin
      #1;
      hiRv = hiReqS;
      hiRd = memData(hiAddrS);
   end

   // Called mid-cycle: checks DUT 0 outputs against the model, then advances the model.
   task automatic evalCycle();
      bit          effRedir, accept, outstanding, newReq;
      logic [15:0] expAddr, expPlus;
      effRedir    = redirect && !halt && !modelHalted;
      outstanding = memBusy && !modelHalted;
      newReq      = imemReq && !memBusy;

      chk("halted", halted, modelHalted);
      if (modelHalted)
         chk("halted_no_req", imemReq, 1'b0);
      if (prevHold) begin
         chk("hold_valid", ifValid, 1'b1);
         chk("hold_inst", ifInst, prevInst);
         chk("hold_pc", ifPc, prevPc);
         chk("hold_pc_plus", ifPcPlus, prevPlus);
      end else if (modelHalted) begin
         chk("halted_no_new_valid", ifValid, 1'b0);
      end
      if (outstanding) begin
         chk("wait_req_held", imemReq, 1'b1);
         chk("wait_addr_held", imemAddr, memAddr);
      end
      if (newReq) begin
         expAddr = ifValid ? expPc + 16'd2 : expPc;
         chk("req_under_backpressure", ifValid && !ifReady, 1'b0);
         chk("req_addr", imemAddr, expAddr);
      end

      accept = ifValid && ifReady && !effRedir;
      if (accept) begin
         expPlus = expPc + 16'd2;
         chk("accept_pc", ifPc, expPc);
         chk("accept_pc_plus", ifPcPlus, expPlus);
         chk("accept_inst", ifInst, memData(expPc));
         accQ.push_back(ifPc);
         accPlusQ.push_back(ifPcPlus);
         expPc = expPlus;
      end
      if (!modelHalted) begin
         if (accept)
            mFetched++;
         if (outstanding || (ifValid && !ifReady))
            mStall++;
      end

      if (effRedir)
         expPc = redirectPc;
      prevHold = ifValid && !ifReady && !effRedir;
      prevInst = ifInst;
      prevPc   = ifPc;
      prevPlus = ifPcPlus;

      if (imemRvalid)
         memBusy = 0;
      if (newReq && !halt) begin
         memBusy = 1;
         memAddr = imemAddr;
         lat     = $urandom_range(latMax, latMin);
      end
      if (halt)
         modelHalted = 1;

      if (memBusy) begin
         nextRv = (lat <= 1);
         nextRd = memData(memAddr);
         if (lat > 0)
            lat--;
      end else begin
         nextRv = ($urandom_range(99, 0) < pSpur);
         nextRd = 16'($urandom);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      evalCycle();
      @(posedge clk);
      #1;
      imemRvalid = nextRv;
      imemRdata  = nextRd;
      if (randIn) begin
         ifReady    = ($urandom_range(99, 0) < pReady);
         redirect   = ($urandom_range(99, 0) < pRedir);
         redirectPc = 16'($urandom) & 16'hFFFE;
      end
   endtask

   initial begin
      bit found;
      rst_n      = 1'b0;
      redirect   = 1'b0;
      redirectPc = '0;
      halt       = 1'b0;
      ifReady    = 1'b1;
      imemRvalid = 1'b0;
      imemRdata  = '0;
      hiRv       = 1'b0;
      hiRd       = '0;

      #12;
      chk("reset_if_valid", ifValid, 1'b0);
      chk("reset_imem_req", imemReq, 1'b0);
      chk("reset_halted", halted, 1'b0);
      chk("reset_if_pc", ifPc, 16'h0000);
      chk("reset_if_inst", ifInst, 16'h0000);
      chk("reset_if_pc_plus", ifPcPlus, 16'h0000);
      chk("reset_hi_req", hiReq, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // sequential fetch, then a 5-cycle stall while pc 4 is presented
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (ifValid && ifPc == 16'h0004) begin
            found = 1;
            break;
         end
         cycle();
      end
      if (!found) timeoutFail("t2_reach_pc4");
      ifReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t2_bp_no_req", imemReq, 1'b0);
         chk("t2_bp_pc", ifPc, 16'h0004);
         chk("t2_bp_valid", ifValid, 1'b1);
      end
      ifReady = 1'b1;
      latMin  = 3;
      latMax  = 3;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (accQ.size() >= 4) begin
            found = 1;
            break;
         end
         cycle();
      end
      if (!found) timeoutFail("t1_four_accepts");
      else begin
         chk("t1_pc0", accQ[0], 16'h0000);
         chk("t1_pc1", accQ[1], 16'h0002);
         chk("t1_pc2", accQ[2], 16'h0004);
         chk("t1_pc3", accQ[3], 16'h0006);
         chk("t1_plus0", accPlusQ[0], 16'h0002);
         chk("t1_plus3", accPlusQ[3], 16'h0008);
      end

      // redirect while the fetch of pc 8 is outstanding
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (memBusy && memAddr == 16'h0008 && !imemRvalid) begin
            found = 1;
            break;
         end
         cycle();
      end
      if (!found) timeoutFail("t3_reach_wait8");
      redirect   = 1'b1;
      redirectPc = 16'h0100;
      cycle();
      redirect = 1'b0;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (accQ.size() >= 5) begin
            found = 1;
            break;
         end
         cycle();
      end
      if (!found) timeoutFail("t3_accept_after_redirect");
      else chk("t3_redirect_pc", accQ[4], 16'h0100);

      // randomized traffic
      pReady = 70; pRedir = 3; pSpur = 10; latMin = 1; latMax = 4;
      randIn = 1;
      for (int i = 0; i < 3000; i++) cycle();
      randIn   = 0;
      redirect = 1'b0;
      ifReady  = 1'b1;
      chk("random_progress", accQ.size() > 100, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched_run", perfFetched, mFetched);
      chk("perf_stall_run", perfStall, mStall);
`endif

      // halt while a request is outstanding
      latMin = 3; latMax = 3; pSpur = 0;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (memBusy && !imemRvalid) begin
            found = 1;
            break;
         end
         cycle();
      end
      if (!found) timeoutFail("t4_reach_wait");
      halt = 1'b1;
      cycle();
      halt = 1'b0;
      pReady = 50; pRedir = 10; pSpur = 30;
      randIn = 1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("t4_no_req", imemReq, 1'b0);
         chk("t4_halted", halted, 1'b1);
         chk("t4_no_valid", ifValid, 1'b0);
      end
      randIn   = 0;
      redirect = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched_halt", perfFetched, mFetched);
      chk("perf_stall_halt", perfStall, mStall);
`endif

      // PC_RESET near the top of the address space wraps
      if (q1.size() < 2) timeoutFail("t5_hi_accepts");
      else begin
         chk("t5_pc0", q1[0], 16'hFFFE);
         chk("t5_pc1", q1[1], 16'h0000);
         chk("t5_plus0", q1Plus[0], 16'h0000);
         chk("t5_plus1", q1Plus[1], 16'h0002);
      end

      // asynchronous reset while dut1 waits on memory
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (hiRv) begin
            found = 1;
            break;
         end
      end
      if (!found) timeoutFail("t5_hi_wait");
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_hi_req", hiReq, 1'b0);
      chk("t5_rst_hi_valid", hiValid, 1'b0);
      chk("t5_rst_hi_pc", hiPc, 16'h0000);
      chk("t5_rst_hi_inst", hiInst, 16'h0000);
      chk("t5_rst_hi_plus", hiPcPlus, 16'h0000);
      chk("t5_rst_halted", halted, 1'b0);
      chk("t5_rst_req", imemReq, 1'b0);
      chk("t5_rst_valid", ifValid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
